// File: rtl/bp_fe_ras_mt.sv
// bp_fe_ras_mt
//   Multi-thread return address stack for the front-end branch predictor.
//   threads_p independent circular stacks share one storage array addressed
//   by {thread, idx}. Each thread keeps a next pointer (slot for the next
//   push), a top-of-stack pointer and an occupancy count. Each stored entry
//   carries the address of the entry beneath it (nos), so a pop follows that
//   link instead of decrementing tos. This is what makes a checkpointed
//   {next, tos, cnt} triple sufficient to undo speculative calls/returns.
//
//   After reset the storage is walked and zeroed one entry per cycle.
//   Operations are only accepted once init_done_o is high.
//
// Ports
//   clk_i, reset_i       clock, asynchronous active-high reset
//   init_done_o          storage clear complete; operations accepted
//   thread_i             thread used for call/return/lookup this cycle
//   call_i, addr_i       push addr_i onto the thread_i stack
//   return_i             pop the thread_i stack
//   v_o, tgt_o           thread_i stack non-empty / predicted return target
//   next_o, tos_o, cnt_o checkpoint view of the thread_i pointers
//   restore_i            overwrite pointers of restore_thread_i with
//   restore_thread_i     w_next_i / w_tos_i / w_cnt_i (cnt clamps to depth)
//   w_next_i, w_tos_i, w_cnt_i
//
// Handshake: there is no backpressure. call_i/return_i/restore_i are
// single-cycle commands, consumed on the rising clock edge when init_done_o
// is high and ignored otherwise. Lookup outputs are combinational.
module bp_fe_ras_mt #(
  parameter int vaddr_width_p   = 39,
  parameter int ras_idx_width_p = 3,
  parameter int threads_p       = 2,
  localparam int thread_width_lp = (threads_p > 1) ? $clog2(threads_p) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  output logic                       init_done_o,

  input  logic [thread_width_lp-1:0] thread_i,
  input  logic                       call_i,
  input  logic [vaddr_width_p-1:0]   addr_i,
  input  logic                       return_i,

  output logic                       v_o,
  output logic [vaddr_width_p-1:0]   tgt_o,
  output logic [ras_idx_width_p-1:0] next_o,
  output logic [ras_idx_width_p-1:0] tos_o,
  output logic [ras_idx_width_p:0]   cnt_o,

  input  logic                       restore_i,
  input  logic [thread_width_lp-1:0] restore_thread_i,
  input  logic [ras_idx_width_p-1:0] w_next_i,
  input  logic [ras_idx_width_p-1:0] w_tos_i,
  input  logic [ras_idx_width_p:0]   w_cnt_i
);

  localparam int depth_lp      = 1 << ras_idx_width_p;
  localparam int entries_lp    = threads_p * depth_lp;
  localparam int mem_addr_w_lp = thread_width_lp + ras_idx_width_p;
  localparam int cnt_width_lp  = ras_idx_width_p + 1;

  localparam logic [cnt_width_lp-1:0]  depth_cnt_lp  = cnt_width_lp'(depth_lp);
  localparam logic [mem_addr_w_lp-1:0] last_entry_lp = mem_addr_w_lp'(entries_lp - 1);

  typedef struct packed {
    logic [ras_idx_width_p-1:0] nos;
    logic [vaddr_width_p-1:0]   addr;
  } entry_s;

  typedef enum logic [1:0] {
    e_reset = 2'd0,
    e_clear = 2'd1,
    e_run   = 2'd2
  } state_e;

  // ---------------------------------------------------------------------
  // Init FSM
  // ---------------------------------------------------------------------
  state_e                   state_q, state_d;
  logic [mem_addr_w_lp-1:0] init_cnt_q, init_cnt_d;
  logic                     init_done;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      e_reset: begin
        state_d    = e_clear;
        init_cnt_d = '0;
      end
      e_clear: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == last_entry_lp) begin
          state_d    = e_run;
          init_cnt_d = '0;
        end
      end
      e_run: begin
        state_d = e_run;
      end
      default: begin
        state_d    = e_reset;
        init_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= e_reset;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  assign init_done = (state_q == e_run);

  // ---------------------------------------------------------------------
  // Storage and per-thread pointers
  // ---------------------------------------------------------------------
  entry_s mem_q [entries_lp];

  logic [ras_idx_width_p-1:0] next_q [threads_p];
  logic [ras_idx_width_p-1:0] next_d [threads_p];
  logic [ras_idx_width_p-1:0] tos_q  [threads_p];
  logic [ras_idx_width_p-1:0] tos_d  [threads_p];
  logic [cnt_width_lp-1:0]    cnt_q  [threads_p];
  logic [cnt_width_lp-1:0]    cnt_d  [threads_p];

  // Lookup for the selected thread
  logic [ras_idx_width_p-1:0] cur_next, cur_tos;
  logic [cnt_width_lp-1:0]    cur_cnt;
  entry_s                     top_entry;

  assign cur_next  = next_q[thread_i];
  assign cur_tos   = tos_q[thread_i];
  assign cur_cnt   = cnt_q[thread_i];
  assign top_entry = mem_q[{thread_i, cur_tos}];

  // An op on thread_i is dropped when the same thread is being restored:
  // the redirect supersedes whatever predecode saw this cycle.
  logic op_en, push, pop;
  assign op_en = init_done && !(restore_i && (restore_thread_i == thread_i));
  assign push  = op_en && call_i;
  assign pop   = op_en && return_i;

  logic [cnt_width_lp-1:0] w_cnt_clamped;
  assign w_cnt_clamped = (w_cnt_i > depth_cnt_lp) ? depth_cnt_lp : w_cnt_i;

  // Single write port shared by the clear walk and pushes.
  logic                     wr_en;
  logic [mem_addr_w_lp-1:0] wr_addr;
  entry_s                   wr_data;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (state_q == e_clear) begin
      wr_en   = 1'b1;
      wr_addr = init_cnt_q;
    end else if (push) begin
      wr_en        = 1'b1;
      wr_addr      = {thread_i, cur_next};
      // Co-routine swap: the new entry replaces the popped top, so it links
      // to what was beneath that top rather than to the top itself.
      wr_data.nos  = pop ? top_entry.nos : cur_tos;
      wr_data.addr = addr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    for (int t = 0; t < threads_p; t++) begin
      next_d[t] = next_q[t];
      tos_d[t]  = tos_q[t];
      cnt_d[t]  = cnt_q[t];
      if (thread_i == thread_width_lp'(t)) begin
        if (push) begin
          next_d[t] = cur_next + 1'b1;
          tos_d[t]  = cur_next;
          if (!pop && (cur_cnt != depth_cnt_lp)) begin
            cnt_d[t] = cur_cnt + 1'b1;
          end
        end else if (pop) begin
          tos_d[t] = top_entry.nos;
          if (cur_cnt != '0) begin
            cnt_d[t] = cur_cnt - 1'b1;
          end
        end
      end
      if (init_done && restore_i && (restore_thread_i == thread_width_lp'(t))) begin
        next_d[t] = w_next_i;
        tos_d[t]  = w_tos_i;
        cnt_d[t]  = w_cnt_clamped;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int t = 0; t < threads_p; t++) begin
        next_q[t] <= '0;
        tos_q[t]  <= '0;
        cnt_q[t]  <= '0;
      end
    end else begin
      for (int t = 0; t < threads_p; t++) begin
        next_q[t] <= next_d[t];
        tos_q[t]  <= tos_d[t];
        cnt_q[t]  <= cnt_d[t];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign init_done_o = init_done;
  assign v_o         = init_done && (cur_cnt != '0);
  assign tgt_o       = top_entry.addr;
  assign next_o      = cur_next;
  assign tos_o       = cur_tos;
  assign cnt_o       = cur_cnt;

endmodule
